// File: rtl/x_word_des.sv
// x_word_des: byte-stream to word deserializer with holding register.
// Optional per-word parity output enabled by X_WORD_DES_PARITY_EN.
module x_word_des #(
  parameter int BYTE_W    = 8,
  parameter int NBYTES    = 8,
  parameter int LSB_FIRST = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [BYTE_W-1:0]          i_byte,
  output logic                       o_ready,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [NBYTES*BYTE_W-1:0]   o_data,
  output logic [$clog2(NBYTES+1)-1:0] o_count,
  output logic                       o_drop,
`ifdef X_WORD_DES_PARITY_EN
  output logic                       o_timeout,
  output logic                       o_parity
`else
  output logic                       o_timeout
`endif
);

  localparam int W  = NBYTES * BYTE_W;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL = CW'(NBYTES);
  localparam logic [CW-1:0] NEAR = CW'(NBYTES - 1);
  localparam logic [IW-1:0] LAST =
    IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0]  asm_q, asm_d, shifted;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          valid_q, valid_d;
  logic          drop_q, tmo_q, tmo_d;
  logic          acc, full, free;
  logic          ld_full, ld_acc, clr;

  assign full    = (cnt_q == FULL);
  assign o_ready = !full;
  assign acc     = i_valid & o_ready;
  assign free    = !valid_q | i_ready;

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_count   = cnt_q;
  assign o_drop    = drop_q;
  assign o_timeout = tmo_q;

  always_comb begin
    shifted = '0;
    if (LSB_FIRST != 0)
      shifted = {i_byte, asm_q[W-1:BYTE_W]};
    else
      shifted = {asm_q[W-BYTE_W-1:0], i_byte};
  end

  always_comb begin
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    data_d  = data_q;
    valid_d = valid_q & !i_ready;
    tmo_d   = 1'b0;
    ld_full = 1'b0;
    ld_acc  = 1'b0;
    clr     = 1'b0;
    if (full) begin
      idle_d = '0;
      if (free) begin
        ld_full = 1'b1;
        data_d  = asm_q;
        valid_d = 1'b1;
        cnt_d   = '0;
        asm_d   = '0;
      end
    end else if (acc) begin
      asm_d  = shifted;
      cnt_d  = cnt_q + 1'b1;
      idle_d = '0;
      if (cnt_q == NEAR && free) begin
        ld_acc  = 1'b1;
        data_d  = shifted;
        valid_d = 1'b1;
        cnt_d   = '0;
        asm_d   = '0;
      end
    end else if (cnt_q == '0) begin
      idle_d = '0;
    end else if (TIMEOUT > 0) begin
      // expiry lands on the edge where the idle count would hit TIMEOUT
      if (idle_q == LAST) begin
        clr    = 1'b1;
        tmo_d  = 1'b1;
        cnt_d  = '0;
        asm_d  = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      asm_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      drop_q  <= i_valid & !o_ready;
      tmo_q   <= tmo_d;
    end
  end

`ifdef X_WORD_DES_PARITY_EN
  logic par_q, par_d, par_nx;
  logic opar_q, opar_d;

  assign par_nx   = par_q ^ (^i_byte);
  assign o_parity = opar_q;

  always_comb begin
    par_d  = par_q;
    opar_d = opar_q;
    if (ld_full) begin
      opar_d = par_q;
      par_d  = 1'b0;
    end else if (ld_acc) begin
      opar_d = par_nx;
      par_d  = 1'b0;
    end else if (acc) begin
      par_d = par_nx;
    end else if (clr) begin
      par_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      par_q  <= 1'b0;
      opar_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      opar_q <= opar_d;
    end
  end
`endif

endmodule

// File: tb/tb_x_word_des.sv
// Bench for x_word_des: MSB-first/timeout and LSB-first instances.
// Scoreboard queues hold expected {parity, word} per instance.
module tb_x_word_des;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       va = 1'b0;
  logic       vb = 1'b0;
  logic [7:0] byt = '0;
  logic       rdy = 1'b0;

  logic        a_rdy, a_vld, a_drop, a_tmo;
  logic [63:0] a_data;
  logic [3:0]  a_cnt;
  logic        b_rdy, b_vld, b_drop, b_tmo;
  logic [63:0] b_data;
  logic [3:0]  b_cnt;
`ifdef X_WORD_DES_PARITY_EN
  logic a_par, b_par;
`endif

  int checks = 0;
  int errors = 0;
  int drop_a = 0;
  logic [64:0] qa[$];
  logic [64:0] qb[$];

  always #5 clk = ~clk;

  x_word_des #(.TIMEOUT(16)) u_a (
    .i_clk(clk), .i_rst(rst_n),
    .i_valid(va), .i_byte(byt),
    .o_ready(a_rdy), .o_valid(a_vld),
    .i_ready(rdy), .o_data(a_data),
    .o_count(a_cnt), .o_drop(a_drop),
`ifdef X_WORD_DES_PARITY_EN
    .o_timeout(a_tmo), .o_parity(a_par)
`else
    .o_timeout(a_tmo)
`endif
  );

  x_word_des #(.LSB_FIRST(1)) u_b (
    .i_clk(clk), .i_rst(rst_n),
    .i_valid(vb), .i_byte(byt),
    .o_ready(b_rdy), .o_valid(b_vld),
    .i_ready(rdy), .o_data(b_data),
    .o_count(b_cnt), .o_drop(b_drop),
`ifdef X_WORD_DES_PARITY_EN
    .o_timeout(b_tmo), .o_parity(b_par)
`else
    .o_timeout(b_tmo)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rev(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = w[8*(7-i) +: 8];
    return r;
  endfunction

  task automatic push(input logic [63:0] w, input bit ta,
                      input bit tb);
    if (ta) qa.push_back({^w, w});
    if (tb) qb.push_back({^w, rev(w)});
  endtask

  task automatic send(input logic [7:0] b, input bit ta,
                      input bit tb);
    @(posedge clk);
    #1;
    va  = ta;
    vb  = tb;
    byt = b;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input bit ta,
                           input bit tb, input int n);
    for (int i = 0; i < n; i++)
      send(w[8*(7-i) +: 8], ta, tb);
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n) begin
      if (a_drop) drop_a++;
      if (a_vld && rdy) begin
        if (qa.size() == 0) chk("a_extra", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_data", a_data, e[63:0]);
`ifdef X_WORD_DES_PARITY_EN
          chk("a_par", a_par, e[64]);
`endif
        end
      end
      if (b_vld && rdy) begin
        if (qb.size() == 0) chk("b_extra", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_data", b_data, e[63:0]);
`ifdef X_WORD_DES_PARITY_EN
          chk("b_par", b_par, e[64]);
`endif
        end
      end
    end
  end

  initial begin
    int  n;
    bit  seen;

    #12;
    chk("rst_vld", a_vld, 0);
    chk("rst_data", a_data, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_rdy", a_rdy, 1);
    chk("rst_drop", a_drop, 0);
    chk("rst_tmo", a_tmo, 0);
    chk("rst_b_rdy", b_rdy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy   = 1'b1;

    // back-to-back word, downstream always ready
    push(64'h0102030405060708, 1, 1);
    send_word(64'h0102030405060708, 1, 1, 8);
    idle();
    @(negedge clk);
    chk("t1_vld", a_vld, 1);
    chk("t1_b_vld", b_vld, 1);
    chk("t1_cnt", a_cnt, 0);
    @(negedge clk);
    chk("t1_vld_off", a_vld, 0);
    chk("t1_nodrop", drop_a, 0);

    // back-pressure: two words plus one dropped symbol
    rdy = 1'b0;
    push(64'h1112131415161718, 1, 1);
    push(64'h2122232425262728, 1, 1);
    send_word(64'h1112131415161718, 1, 1, 8);
    send_word(64'h2122232425262728, 1, 1, 8);
    send(8'h99, 1, 1);
    idle();
    @(negedge clk);
    chk("t2_drop", a_drop, 1);
    chk("t2_b_drop", b_drop, 1);
    chk("t2_rdy", a_rdy, 0);
    chk("t2_cnt", a_cnt, 8);
    chk("t2_vld", a_vld, 1);
    chk("t2_hold", a_data, 64'h1112131415161718);
    @(negedge clk);
    chk("t2_drop_off", a_drop, 0);
    chk("t2_stable", a_data, 64'h1112131415161718);
    @(posedge clk);
    #1;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    @(negedge clk);
    chk("t2_vld2", a_vld, 1);
    chk("t2_word2", a_data, 64'h2122232425262728);
    chk("t2_rdy2", a_rdy, 1);
    chk("t2_cnt2", a_cnt, 0);
    chk("t2_drops", drop_a, 1);
    rdy = 1'b1;
    idle();
    idle();

    // idle timeout on the MSB-first instance only
    send_word(64'hA1A2A30000000000, 1, 0, 3);
    idle();
    @(negedge clk);
    chk("t3_cnt3", a_cnt, 3);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (a_tmo) seen = 1'b1;
    end
    chk("t3_seen", seen, 1);
    chk("t3_delay", n, 16);
    chk("t3_cnt0", a_cnt, 0);
    @(negedge clk);
    chk("t3_pulse", a_tmo, 0);
    push(64'hB1B2B3B4B5B6B7B8, 1, 0);
    send_word(64'hB1B2B3B4B5B6B7B8, 1, 0, 8);
    idle();
    idle();

    // asynchronous reset mid-word and mid-handshake
    rdy = 1'b0;
    send_word(64'hC1C2C3C4C5C6C7C8, 1, 1, 8);
    send_word(64'hD1D2D3D4D5D6D7D8, 1, 1, 5);
    idle();
    @(negedge clk);
    chk("t4_vld", a_vld, 1);
    chk("t4_data", a_data, 64'hC1C2C3C4C5C6C7C8);
    chk("t4_cnt5", a_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_r_vld", a_vld, 0);
    chk("t4_r_data", a_data, 0);
    chk("t4_r_cnt", a_cnt, 0);
    chk("t4_r_rdy", a_rdy, 1);
    chk("t4_r_bvld", b_vld, 0);
    chk("t4_r_bdata", b_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy   = 1'b1;
    push(64'hE1E2E3E4E5E6E7E8, 1, 1);
    send_word(64'hE1E2E3E4E5E6E7E8, 1, 1, 7);
    idle();
    @(negedge clk);
    chk("t4_noword", a_vld, 0);
    chk("t4_cnt7", a_cnt, 7);
    send(8'hE8, 1, 1);
    idle();
    @(negedge clk);
    chk("t4_word", a_vld, 1);

`ifdef X_WORD_DES_PARITY_EN
    push(64'h0102040810204080, 1, 1);
    send_word(64'h0102040810204080, 1, 1, 8);
    push(64'h0102040810204000, 1, 1);
    send_word(64'h0102040810204000, 1, 1, 8);
    idle();
    @(negedge clk);
    chk("t5_par1", a_par, 1);
    chk("t5_b_par1", b_par, 1);
`endif

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x_word_des.md
Name: x_word_des

Overview:
- Parametrised byte-stream deserializer; successor to x_byte_des.
- Accepts BYTE_W-bit symbols on a valid/ready input and assembles NBYTES symbols into one word.
- Presents the word on a valid/ready output through a one-deep holding register, so assembly of the next word overlaps output back-pressure.
- Adds configurable byte order, idle timeout that discards partial words, and drop reporting; sits between the serial command front-end and the delay-line control logic.

Parameters:
- BYTE_W, 8, symbol width in bits (>=1).
- NBYTES, 8, symbols per output word (>=2).
- LSB_FIRST, 0: 0 = first symbol lands in the top of o_data; 1 = first symbol lands in o_data[BYTE_W-1:0].
- TIMEOUT, 0, idle cycles after which a partial word is discarded; 0 disables the timeout.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  input symbol valid.
- i_byte  input  BYTE_W  input symbol.
- o_ready  output  1  deserializer can accept a symbol this cycle.
- o_valid  output  1  assembled word valid.
- i_ready  input  1  downstream accepts the word.
- o_data  output  NBYTES*BYTE_W  assembled word; stable while o_valid=1.
- o_count  output  $clog2(NBYTES+1)  symbols currently held in the assembly register.
- o_drop  output  1  one-cycle pulse: i_valid=1 while o_ready=0; the symbol is lost.
- o_timeout  output  1  one-cycle pulse: a partial word was discarded by the timeout.

Behaviour:
- Reset values (async, i_rst=0): o_valid=0, o_data=0, o_count=0, o_drop=0, o_timeout=0, idle counter=0, o_ready=1.
- Accept condition: acc = i_valid & o_ready.
  - Each acc shifts i_byte into the assembly register per LSB_FIRST and increments the count.
- Completion: the acc that brings the count to NBYTES is the last symbol.
  - If the holding register is free (o_valid=0, or o_valid&i_ready this cycle), the word moves to o_data.
  - In that case o_valid=1 next cycle and o_count returns to 0.
  - Latency: last symbol accepted in cycle N gives o_valid=1 in cycle N+1.
- Back-pressure: if the holding register is busy at completion, the assembly register keeps the full word (o_count=NBYTES) and o_ready=0.
  - The word transfers in the cycle o_valid&i_ready occurs; o_ready=1 the cycle after.
  - o_ready is registered: o_ready = !(o_count==NBYTES).
- Output handshake:
  - o_valid clears after a cycle with o_valid&i_ready, unless a new word transfers in the same cycle; then o_valid stays 1 with the new o_data.
  - o_data never changes while o_valid=1 and i_ready=0.
- Drop: i_valid&!o_ready pulses o_drop for one cycle; the symbol is ignored and no state changes.
- Timeout (TIMEOUT>0):
  - The idle counter clears on any acc or when o_count=0.
  - It increments each cycle with 0<o_count<NBYTES and no acc.
  - On reaching TIMEOUT: o_count goes to 0, the partial data is discarded, and o_timeout pulses one cycle.
  - A full word (o_count=NBYTES) never times out.
  - An acc in the same cycle as the expiry wins: the count increments and the counter clears.
- Reset mid-word or mid-handshake discards everything immediately; no word is emitted.
- Widths: o_count wraps never; maximum value NBYTES.

Optional Feature:
- Macro X_WORD_DES_PARITY_EN.
- Defined:
  - Adds output port o_parity (1 bit), the XOR of all accepted symbols of the word.
  - o_parity is accumulated per acc, transferred with o_data, and valid with o_valid.
  - It is reset to 0 and cleared together with the count (completion, timeout).
- Undefined: no o_parity port and no accumulator logic; behaviour is otherwise identical.

Test Plan:
- Default parameters, i_ready=1, send 01..08 back-to-back -> o_valid=1 for one cycle after the 8th symbol, o_data=0x0102030405060708, o_count back to 0, o_drop never asserted.
- LSB_FIRST=1, same stimulus -> o_data=0x0807060504030201.
- i_ready=0, send 16 symbols continuously:
  - First word is held on o_data; second word fills and o_ready drops.
  - Symbol 17 gives an o_drop pulse.
  - Raising i_ready for one cycle makes o_data the second word with o_valid still 1; o_ready returns high the next cycle.
- TIMEOUT=16: send 3 symbols, then idle -> o_timeout pulses exactly 16 cycles after the 3rd symbol and o_count=0; then 8 new symbols produce only those 8 in o_data.
- Assert i_rst=0 asynchronously after 5 symbols and while o_valid=1 -> all outputs return to their reset values without waiting for a clock edge; after release, a full 8-symbol word is needed for the next o_valid.
- With X_WORD_DES_PARITY_EN, send 01,02,04,08,10,20,40,80 -> o_parity=0 (0xFF has even parity); replace the final symbol with 00 -> o_parity=1.
